// File: rtl/keycode_router.sv
// keycode_router: splits 8-byte USB HID boot-keyboard reports into up to two
// held keycodes per player and publishes them atomically once per report.
//
// Ports:
//   Clk, Reset                  - clock, synchronous active-high reset
//   in_data/in_valid/in_sof     - report byte stream; in_sof marks byte 0
//   in_ready                    - byte accepted on edges with in_valid && in_ready
//   p1_keycode0/1, p2_keycode0/1 - per-player keys in order of appearance, 00 = none
//   mods                        - modifier byte of the last committed report
//   keys_valid                  - one-cycle pulse when the key outputs update
//   drop                        - one-cycle pulse when a byte or report is discarded
module keycode_router #(
  parameter logic [7:0] P1_LEFT  = 8'h04,
  parameter logic [7:0] P1_RIGHT = 8'h07,
  parameter logic [7:0] P1_JUMP  = 8'h1A,
  parameter logic [7:0] P2_LEFT  = 8'h50,
  parameter logic [7:0] P2_RIGHT = 8'h4F,
  parameter logic [7:0] P2_JUMP  = 8'h52
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_sof,
  output logic       in_ready,
  output logic [7:0] p1_keycode0,
  output logic [7:0] p1_keycode1,
  output logic [7:0] p2_keycode0,
  output logic [7:0] p2_keycode1,
  output logic [7:0] mods,
  output logic       keys_valid,
  output logic       drop
);

  localparam int unsigned SLOT_W    = 3;
  localparam logic [7:0]  KEY_NONE  = 8'h00;
  localparam logic [7:0]  KEY_ROLLOVER = 8'h01;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(5);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RSVD,
    S_KEYS,
    S_COMMIT
  } state_e;

  state_e            state_q;
  logic [SLOT_W-1:0] slot_q;
  logic              ready_q;
  logic              bad_q;

  // Shadow copy of the report being parsed
  logic [7:0] sh_mods_q;
  logic [7:0] sh_p1_k0_q, sh_p1_k1_q;
  logic [7:0] sh_p2_k0_q, sh_p2_k1_q;

  // Published outputs
  logic [7:0] p1_k0_q, p1_k1_q, p2_k0_q, p2_k1_q, mods_q;
  logic       keys_valid_q;
  logic       drop_q;

  logic accept;
  logic p1_hit;
  logic p2_hit;

  assign accept = in_valid && ready_q;
  assign p1_hit = (in_data == P1_LEFT) || (in_data == P1_RIGHT) || (in_data == P1_JUMP);
  assign p2_hit = (in_data == P2_LEFT) || (in_data == P2_RIGHT) || (in_data == P2_JUMP);

  // Insert code into a two-entry slot pair {k1,k0}: skip duplicates,
  // fill k0 first, then k1, ignore once both are occupied.
  function automatic logic [15:0] add_key(input logic [7:0] k1,
                                          input logic [7:0] k0,
                                          input logic [7:0] code);
    logic [15:0] res;
    res = {k1, k0};
    if ((code != k0) && (code != k1)) begin
      if (k0 == KEY_NONE) begin
        res = {k1, code};
      end else if (k1 == KEY_NONE) begin
        res = {code, k0};
      end
    end
    return res;
  endfunction

  // Report parser FSM with registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      slot_q       <= '0;
      ready_q      <= 1'b1;
      bad_q        <= 1'b0;
      sh_mods_q    <= KEY_NONE;
      sh_p1_k0_q   <= KEY_NONE;
      sh_p1_k1_q   <= KEY_NONE;
      sh_p2_k0_q   <= KEY_NONE;
      sh_p2_k1_q   <= KEY_NONE;
      p1_k0_q      <= KEY_NONE;
      p1_k1_q      <= KEY_NONE;
      p2_k0_q      <= KEY_NONE;
      p2_k1_q      <= KEY_NONE;
      mods_q       <= KEY_NONE;
      keys_valid_q <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      keys_valid_q <= 1'b0;
      drop_q       <= 1'b0;

      if (accept && in_sof) begin
        // A start-of-report byte always begins a fresh report; outside IDLE it
        // aborts the partial one (COMMIT never accepts, so it is not a case here).
        drop_q     <= (state_q != S_IDLE);
        sh_mods_q  <= in_data;
        sh_p1_k0_q <= KEY_NONE;
        sh_p1_k1_q <= KEY_NONE;
        sh_p2_k0_q <= KEY_NONE;
        sh_p2_k1_q <= KEY_NONE;
        bad_q      <= 1'b0;
        slot_q     <= '0;
        state_q    <= S_RSVD;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (accept) begin
              drop_q <= 1'b1;
            end
          end

          S_RSVD: begin
            if (accept) begin
              slot_q  <= '0;
              state_q <= S_KEYS;
            end
          end

          S_KEYS: begin
            if (accept) begin
              if (in_data == KEY_ROLLOVER) begin
                bad_q <= 1'b1;
              end
              if (p1_hit) begin
                {sh_p1_k1_q, sh_p1_k0_q} <= add_key(sh_p1_k1_q, sh_p1_k0_q, in_data);
              end
              if (p2_hit) begin
                {sh_p2_k1_q, sh_p2_k0_q} <= add_key(sh_p2_k1_q, sh_p2_k0_q, in_data);
              end
              if (slot_q == LAST_SLOT) begin
                ready_q <= 1'b0;
                state_q <= S_COMMIT;
              end else begin
                slot_q <= slot_q + SLOT_W'(1);
              end
            end
          end

          S_COMMIT: begin
            ready_q <= 1'b1;
            state_q <= S_IDLE;
            if (bad_q) begin
              drop_q <= 1'b1;
            end else begin
              p1_k0_q      <= sh_p1_k0_q;
              p1_k1_q      <= sh_p1_k1_q;
              p2_k0_q      <= sh_p2_k0_q;
              p2_k1_q      <= sh_p2_k1_q;
              mods_q       <= sh_mods_q;
              keys_valid_q <= 1'b1;
            end
          end

          default: begin
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign in_ready    = ready_q;
  assign p1_keycode0 = p1_k0_q;
  assign p1_keycode1 = p1_k1_q;
  assign p2_keycode0 = p2_k0_q;
  assign p2_keycode1 = p2_k1_q;
  assign mods        = mods_q;
  assign keys_valid  = keys_valid_q;
  assign drop        = drop_q;

endmodule

// File: doc/keycode_router.md
# keycode_router

Splits parsed USB HID boot-keyboard reports into per-player key pairs for the two player (ball) instances. It sits between the keyboard interface and the movement logic. It consumes an 8-byte report stream over a valid/ready handshake and publishes, atomically once per report, up to two held keycodes per player in the `keycode0`/`keycode1` form the ball module consumes. Keys not mapped to either player are dropped. Rollover-error reports are discarded.

## Interface
- `P1_LEFT`, 8'h04, player-1 left key (A)
- `P1_RIGHT`, 8'h07, player-1 right key (D)
- `P1_JUMP`, 8'h1A, player-1 jump key (W)
- `P2_LEFT`, 8'h50, player-2 left key (left arrow)
- `P2_RIGHT`, 8'h4F, player-2 right key (right arrow)
- `P2_JUMP`, 8'h52, player-2 jump key (up arrow)
- `Clk` in 1, single clock; everything is synchronous to its rising edge
- `Reset` in 1, synchronous, active-high
- `in_data` in 8, report byte
- `in_valid` in 1, `in_data` is valid
- `in_sof` in 1, qualifies the current byte as report byte 0 (modifiers)
- `in_ready` out 1, block accepts a byte this cycle
- `p1_keycode0`, `p1_keycode1` out 8 each, player-1 keys in order of appearance; 8'h00 = none
- `p2_keycode0`, `p2_keycode1` out 8 each, player-2 keys, same rules
- `mods` out 8, modifier byte of the last committed report
- `keys_valid` out 1, one-cycle pulse when outputs update
- `drop` out 1, one-cycle pulse when a report or byte is discarded

## Operation
- A byte is accepted on an edge where `in_valid && in_ready`.
- Report layout: byte 0 = modifiers, byte 1 = reserved (ignored), bytes 2–7 = six key slots.
- States and transitions:
  - IDLE: waits for an accepted byte with `in_sof`=1. That byte goes to shadow mods; go to RSVD. An accepted byte with `in_sof`=0 is discarded and pulses `drop`.
  - RSVD: accept byte 1; go to KEYS with slot counter = 0.
  - KEYS: accept slots 0..5 (3-bit counter). After slot 5, go to COMMIT.
  - COMMIT: `in_ready`=0 for this one cycle. Shadow registers copy to the outputs; go to IDLE.
- Any accepted byte with `in_sof`=1 in RSVD or KEYS aborts the partial report: `drop` pulses, the shadow state is cleared, and the byte is taken as a new byte 0 (state RSVD).
- Slot classification:
  - 8'h00 is ignored.
  - A code equal to any `P1_*` parameter fills the first empty player-1 shadow slot (`keycode0` first, then `keycode1`).
  - Likewise `P2_*` fills the player-2 shadow slots.
  - Unmapped codes are ignored.
- Duplicates: a code already in that player's shadow is not stored again.
- A third matching key for a player is ignored; the first two in slot order win.
- Rollover error: if any key slot equals 8'h01, the report is marked bad. At COMMIT the outputs hold their previous values, `keys_valid` stays 0 and `drop` pulses.
- `in_ready` = 1 in every state except COMMIT.
- Reset mid-report discards all shadow state.

## Timing
- Reset values:
  - All keycode outputs = 8'h00 and `mods` = 8'h00.
  - `keys_valid` = 0, `drop` = 0, `in_ready` = 1, state IDLE, shadows cleared.
- Latency: slot 5 is accepted at edge k, so COMMIT holds during cycle k..k+1. New outputs and the `keys_valid` pulse appear after edge k+1, and `keys_valid` is high for exactly that one cycle.
- Minimum report period is 9 cycles (8 accept cycles + COMMIT). A byte presented during COMMIT waits; it is not lost.
- Outputs are stable between commits and never show a partially parsed report.
- `drop` for a stray or aborted byte pulses in the cycle after the accepting edge.
- `drop` for a rollover report pulses in the cycle after COMMIT.
- Gaps (`in_valid`=0) are allowed anywhere and stall the FSM with no timeout.

## Test plan
- Report 00,00,04,1A,00,00,00,00 sent back-to-back → 9 cycles after the first byte: p1 = 04/1A, p2 = 00/00, `mods`=00, and `keys_valid` pulses once.
- Report 02,00,50,07,52,04,1A,4F → p1 = 07/04, p2 = 50/52, `mods`=02. The W and right-arrow keys are dropped. `in_ready`=0 only in the COMMIT cycle.
- After the previous report, send 00,00,01,01,01,01,01,01 → outputs are unchanged, `keys_valid`=0, `drop` pulses once.
- Send 00,00,04 with `in_sof`, then a new `in_sof` byte 00 and the full report 00,00,4F,4F,00,00,00,00 → `drop` pulses at the abort. Final outputs: p2 = 4F/00, p1 = 00/00.
- Send three bytes with `in_sof`=0 while in IDLE → three `drop` pulses and no output change.
- Assert `Reset` for one cycle during slot 3 of a report → all outputs are 00 on the next cycle. A following clean report 00,00,1A,00,00,00,00,00 yields p1 = 1A/00.
